// File: rtl/can_crc_checker.sv
// Receive-side CAN CRC-15 checker: accumulates CRC over SOF..data, captures the CRC field, checks delimiter.
// Optional macro CAN_CRC_CHK_DELIM_EN adds the delimiter state and form_err reporting.
module can_crc_checker #(
    parameter int MAX_LEN = 103
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_frame_start,
    input  logic [6:0]  i_crc_len,
    input  logic        i_bit_valid,
    input  logic        i_bit_in,
    input  logic        i_abort,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_crc_ok,
    output logic        o_crc_err,
    output logic        o_form_err,
    output logic [14:0] o_crc_calc,
    output logic [14:0] o_crc_rx
);
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_RXCRC, S_DELIM} state_t;

    localparam logic [6:0] LP_MAX = 7'(MAX_LEN);

    state_t      r_state;
    logic [6:0]  r_cnt;
    logic [3:0]  r_rx_cnt;
    logic [14:0] r_crc_calc;
    logic [14:0] r_crc_rx;
    logic        r_busy;
    logic        r_done;
    logic        r_crc_ok;
    logic        r_crc_err;

    logic [6:0]  w_len;
    logic [14:0] w_rx_nxt;

    function automatic logic [14:0] f_crc_step(input logic [14:0] c, input logic b);
        logic nxt;
        nxt = b ^ c[14];
        return {c[13:0], 1'b0} ^ (nxt ? 15'h4599 : 15'h0000);
    endfunction

    assign w_len    = (i_crc_len > LP_MAX) ? LP_MAX : i_crc_len;
    assign w_rx_nxt = {r_crc_rx[13:0], i_bit_in};

`ifdef CAN_CRC_CHK_DELIM_EN
    logic r_form_err;
    assign o_form_err = r_form_err;
`else
    assign o_form_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rx_cnt   <= '0;
            r_crc_calc <= '0;
            r_crc_rx   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_crc_ok   <= 1'b0;
            r_crc_err  <= 1'b0;
`ifdef CAN_CRC_CHK_DELIM_EN
            r_form_err <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (i_frame_start) begin
                r_busy    <= 1'b1;
                r_crc_ok  <= 1'b0;
                r_crc_err <= 1'b0;
`ifdef CAN_CRC_CHK_DELIM_EN
                r_form_err <= 1'b0;
`endif
                // A strobe coincident with frame_start is the first bit of whichever state is entered
                if (w_len == 7'd0) begin
                    r_state    <= S_RXCRC;
                    r_cnt      <= '0;
                    r_crc_calc <= '0;
                    r_rx_cnt   <= 4'(i_bit_valid);
                    r_crc_rx   <= i_bit_valid ? {14'h0, i_bit_in} : 15'h0000;
                end else begin
                    r_crc_calc <= i_bit_valid ? f_crc_step(15'h0000, i_bit_in) : 15'h0000;
                    r_cnt      <= w_len - 7'(i_bit_valid);
                    r_rx_cnt   <= '0;
                    r_crc_rx   <= '0;
                    r_state    <= (i_bit_valid && w_len == 7'd1) ? S_RXCRC : S_ACCUM;
                end
            end else if (i_abort && r_state != S_IDLE) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else if (i_bit_valid) begin
                case (r_state)
                    S_ACCUM: begin
                        r_crc_calc <= f_crc_step(r_crc_calc, i_bit_in);
                        r_cnt      <= r_cnt - 7'd1;
                        if (r_cnt == 7'd1) r_state <= S_RXCRC;
                    end
                    S_RXCRC: begin
                        r_crc_rx <= w_rx_nxt;
                        r_rx_cnt <= r_rx_cnt + 4'd1;
                        if (r_rx_cnt == 4'd14) begin
`ifdef CAN_CRC_CHK_DELIM_EN
                            r_state <= S_DELIM;
`else
                            r_state   <= S_IDLE;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_crc_ok  <= (w_rx_nxt == r_crc_calc);
                            r_crc_err <= (w_rx_nxt != r_crc_calc);
`endif
                        end
                    end
`ifdef CAN_CRC_CHK_DELIM_EN
                    S_DELIM: begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_crc_ok   <= (r_crc_rx == r_crc_calc);
                        r_crc_err  <= (r_crc_rx != r_crc_calc);
                        r_form_err <= !i_bit_in;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_crc_ok   = r_crc_ok;
    assign o_crc_err  = r_crc_err;
    assign o_crc_calc = r_crc_calc;
    assign o_crc_rx   = r_crc_rx;
endmodule

// File: tb/tb_can_crc_checker.sv
// Directed, table-driven bench for can_crc_checker; follows CAN_CRC_CHK_DELIM_EN for delimiter expectations.
module tb_can_crc_checker;
    localparam int MAXL = 103;
`ifdef CAN_CRC_CHK_DELIM_EN
    localparam bit DLM = 1'b1;
`else
    localparam bit DLM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_frame_start = 1'b0;
    logic [6:0]  i_crc_len = '0;
    logic        i_bit_valid = 1'b0;
    logic        i_bit_in = 1'b1;
    logic        i_abort = 1'b0;
    logic        o_busy, o_done, o_crc_ok, o_crc_err, o_form_err;
    logic [14:0] o_crc_calc, o_crc_rx;

    int n_chk = 0;
    int n_pass = 0;
    int done_cnt = 0;

    can_crc_checker #(.MAX_LEN(MAXL)) dut (
        .clk(clk), .reset(reset), .i_frame_start(i_frame_start), .i_crc_len(i_crc_len),
        .i_bit_valid(i_bit_valid), .i_bit_in(i_bit_in), .i_abort(i_abort),
        .o_busy(o_busy), .o_done(o_done), .o_crc_ok(o_crc_ok), .o_crc_err(o_crc_err),
        .o_form_err(o_form_err), .o_crc_calc(o_crc_calc), .o_crc_rx(o_crc_rx)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (o_done) done_cnt++;

    typedef struct {
        string       name;
        logic [6:0]  len;
        logic [7:0]  data;
        logic [14:0] crc;
        logic        delim;
        int          gap;
        logic [14:0] e_calc;
        logic        e_ok;
        logic        e_form;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // All stimulus tasks start and end just after a falling edge
    task automatic send_bit(input logic b, input int gap);
        repeat (gap) @(negedge clk);
        i_bit_valid = 1'b1;
        i_bit_in    = b;
        @(negedge clk);
        i_bit_valid = 1'b0;
    endtask

    task automatic start_frame(input logic [6:0] len, input logic sv, input logic sb);
        i_frame_start = 1'b1;
        i_crc_len     = len;
        i_bit_valid   = sv;
        i_bit_in      = sb;
        @(negedge clk);
        i_frame_start = 1'b0;
        i_bit_valid   = 1'b0;
    endtask

    task automatic tail(input string name, input logic [14:0] crc, input logic delim, input int gap);
        for (int i = 0; i < 15; i++) send_bit(crc[14-i], gap);
        if (DLM) begin
            chk({name, " no early done"}, 32'(o_done), 32'd0);
            send_bit(delim, gap);
            chk({name, " done after delim"}, 32'(o_done), 32'd1);
        end else begin
            chk({name, " done after crc"}, 32'(o_done), 32'd1);
        end
        chk({name, " busy falls with done"}, 32'(o_busy), 32'd0);
        @(negedge clk);
        chk({name, " done one cycle"}, 32'(o_done), 32'd0);
        if (!DLM) send_bit(delim, gap);
    endtask

    task automatic run_frame(input vec_t v);
        int dc0;
        int n;
        dc0 = done_cnt;
        start_frame(v.len, 1'b0, 1'b0);
        chk({v.name, " busy"}, 32'(o_busy), 32'd1);
        n = (int'(v.len) > MAXL) ? MAXL : int'(v.len);
        for (int i = 0; i < n; i++) send_bit((i < 8) ? v.data[i] : 1'b0, v.gap);
        tail(v.name, v.crc, v.delim, v.gap);
        chk({v.name, " calc"}, 32'(o_crc_calc), 32'(v.e_calc));
        chk({v.name, " rx"}, 32'(o_crc_rx), 32'(v.crc));
        chk({v.name, " ok"}, 32'(o_crc_ok), 32'(v.e_ok));
        chk({v.name, " err"}, 32'(o_crc_err), 32'(!v.e_ok));
        chk({v.name, " form"}, 32'(o_form_err), 32'(v.e_form));
        chk({v.name, " single done"}, 32'(done_cnt - dc0), 32'd1);
    endtask

    vec_t vecs[7];

    initial begin
        int dc0;
        vecs[0] = '{"len1_one",   7'd1,   8'h01, 15'h4599, 1'b1, 0, 15'h4599, 1'b1, 1'b0};
        vecs[1] = '{"len2_good",  7'd2,   8'h01, 15'h4EAB, 1'b1, 0, 15'h4EAB, 1'b1, 1'b0};
        vecs[2] = '{"len2_bad",   7'd2,   8'h01, 15'h4EAA, 1'b1, 0, 15'h4EAB, 1'b0, 1'b0};
        vecs[3] = '{"dom_delim",  7'd1,   8'h00, 15'h0000, 1'b0, 0, 15'h0000, 1'b1, DLM};
        vecs[4] = '{"len0_gap3",  7'd0,   8'h00, 15'h0000, 1'b1, 3, 15'h0000, 1'b1, 1'b0};
        vecs[5] = '{"len3_gap1",  7'd3,   8'h07, 15'h53FD, 1'b1, 1, 15'h53FD, 1'b1, 1'b0};
        vecs[6] = '{"clamp127",   7'd127, 8'h00, 15'h0000, 1'b1, 0, 15'h0000, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset busy", 32'(o_busy), 32'd0);
        chk("reset done", 32'(o_done), 32'd0);
        chk("reset flags", {29'd0, o_crc_ok, o_crc_err, o_form_err}, 32'd0);
        chk("reset calc", 32'(o_crc_calc), 32'd0);
        chk("reset rx", 32'(o_crc_rx), 32'd0);

        // Bits in IDLE must be ignored
        send_bit(1'b1, 0);
        chk("idle bit ignored", 32'(o_busy), 32'd0);

        for (int k = 0; k < 7; k++) run_frame(vecs[k]);

        // SOF strobe in the same cycle as frame_start
        dc0 = done_cnt;
        start_frame(7'd2, 1'b1, 1'b1);
        send_bit(1'b0, 0);
        tail("sof_same_cycle", 15'h4EAB, 1'b1, 0);
        chk("sof_same_cycle calc", 32'(o_crc_calc), 32'h4EAB);
        chk("sof_same_cycle ok", 32'(o_crc_ok), 32'd1);
        chk("sof_same_cycle done cnt", 32'(done_cnt - dc0), 32'd1);

        // Restart in RXCRC: the fresh frame carries no stale rx bits
        dc0 = done_cnt;
        start_frame(7'd1, 1'b0, 1'b0);
        send_bit(1'b1, 0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
        start_frame(7'd1, 1'b0, 1'b0);
        chk("restart rx cleared", 32'(o_crc_rx), 32'd0);
        chk("restart calc cleared", 32'(o_crc_calc), 32'd0);
        send_bit(1'b1, 0);
        tail("restart", 15'h4599, 1'b1, 0);
        chk("restart rx", 32'(o_crc_rx), 32'h4599);
        chk("restart ok", 32'(o_crc_ok), 32'd1);
        chk("restart single done", 32'(done_cnt - dc0), 32'd1);

        // Abort in ACCUM
        start_frame(7'd5, 1'b0, 1'b0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk("abort busy", 32'(o_busy), 32'd0);
        dc0 = done_cnt;
        for (int i = 0; i < 22; i++) send_bit(1'b1, 0);
        chk("abort no done", 32'(done_cnt - dc0), 32'd0);
        chk("abort flags low", {30'd0, o_crc_ok, o_crc_err}, 32'd0);

        // Asynchronous reset mid-frame, asserted away from any clock edge
        start_frame(7'd3, 1'b0, 1'b0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        chk("pre-reset busy", 32'(o_busy), 32'd1);
        chk("pre-reset calc", 32'(o_crc_calc), 32'h4EAB);
        #2 reset = 1'b1;
        #1;
        chk("async reset busy", 32'(o_busy), 32'd0);
        chk("async reset calc", 32'(o_crc_calc), 32'd0);
        chk("async reset rx", 32'(o_crc_rx), 32'd0);
        chk("async reset flags", {28'd0, o_done, o_crc_ok, o_crc_err, o_form_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Checker still works after the reset
        run_frame(vecs[1]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/can_crc_checker.md
# can_crc_checker

Receive-side CAN CRC-15 checker. It sits after the bit de-stuffer in the CAN receive path and consumes de-stuffed bits, one per `bit_valid` strobe. From SOF through the last data bit it accumulates CRC-15. It then captures the 15-bit received CRC field and checks the CRC delimiter. It reports the pass/fail verdict once per frame for the receive controller's ACK decision.

## Interface
Parameters:
- `MAX_LEN`, default 103: largest legal `crc_len` (extended frame, 8 data bytes). Values above it are clamped to it.

Ports (clock and reset first):
- `clk`  in  1  clock; all logic is rising-edge.
- `reset`  in  1  reset; asynchronous, active-high.
- `frame_start`  in  1  one-cycle pulse. Restarts the checker from any state and samples `crc_len`.
- `crc_len`  in  7  number of CRC-covered bits, SOF through last data bit. Sampled only on `frame_start`.
- `bit_valid`  in  1  qualifies `bit_in`; one de-stuffed bit per strobe.
- `bit_in`  in  1  de-stuffed bus bit; 0 = dominant.
- `abort`  in  1  error-frame abort; returns to IDLE with no verdict.
- `busy`  out  1  high in ACCUM, RXCRC and DELIM.
- `done`  out  1  one-cycle verdict pulse.
- `crc_ok`  out  1  CRC matched. Held until the next `frame_start`.
- `crc_err`  out  1  CRC mismatch. Held until the next `frame_start`.
- `form_err`  out  1  delimiter was dominant. Held until the next `frame_start`.
- `crc_calc`  out  15  computed CRC.
- `crc_rx`  out  15  received CRC field.

## Operation
- CRC: polynomial 0x4599, register initialised to 0. Per covered bit: `nxt = bit_in ^ crc[14]`; `crc = {crc[13:0],1'b0} ^ (nxt ? 15'h4599 : 0)`.
- States:
  - IDLE: wait for `frame_start`.
  - ACCUM: feed each valid bit into the CRC and decrement the remaining count.
  - RXCRC: shift 15 bits, MSB first, into `crc_rx`. `crc_calc` is frozen.
  - DELIM: one bit, expected recessive.
  - Verdict: `done` pulses, then return to IDLE.
- `frame_start`, from any state:
  - Clears `crc_calc`, `crc_rx`, `crc_ok`, `crc_err`, `form_err`.
  - Loads count = `min(crc_len, MAX_LEN)`.
  - Enters ACCUM, or RXCRC if the count is 0.
- `frame_start` with `bit_valid` in the same cycle: that bit is the first covered bit (SOF) and is accumulated.
- The ACCUM bit that drives the count to 0 moves the FSM to RXCRC. The 15th RXCRC bit moves it to DELIM.
- Verdict on the DELIM bit:
  - `crc_ok = (crc_rx == crc_calc)`.
  - `crc_err = !crc_ok`.
  - `form_err = !bit_in`.
  - `crc_ok` and `form_err` may both be 1.
- `abort` (and not `frame_start`): go to IDLE and leave the verdict flags low. `frame_start` has priority over `abort`.
- `bit_valid` in IDLE is ignored. `bit_valid` gaps of any length are allowed in every state.

## Timing
- Reset values: FSM IDLE; `busy`, `done`, `crc_ok`, `crc_err`, `form_err` = 0; `crc_calc`, `crc_rx` = 15'h0000.
- `crc_calc` updates on the clock edge that samples each valid ACCUM bit.
- `done` and the verdict flags become visible on the edge that samples the DELIM bit, so they are registered and valid the cycle after that strobe. `done` is high for exactly 1 cycle; the FSM is IDLE in the same cycle.
- `busy` rises the cycle after `frame_start` and falls together with `done`.
- Minimum frame time: `crc_len`+16 `bit_valid` strobes. Back-to-back frames are supported because `frame_start` is accepted in the cycle `done` is high.

## Configuration
- `CAN_CRC_CHK_DELIM_EN` defined: DELIM state present, `form_err` driven as above.
- Not defined:
  - DELIM state removed; `form_err` tied to 0.
  - The verdict is taken on the 15th RXCRC bit, with `done` the cycle after that strobe.
  - Minimum frame is `crc_len`+15 strobes.

## Test plan
- `crc_len`=1, bits: 1, then CRC field 15'h4599, delimiter 1 -> `crc_calc`=15'h4599, `done` pulse, `crc_ok`=1, `crc_err`=0, `form_err`=0.
- `crc_len`=2, bits 1,0, then CRC 15'h4EAB, delimiter 1 -> `crc_ok`=1. Same frame with CRC 15'h4EAA -> `crc_err`=1, `crc_ok`=0.
- `crc_len`=1, bit 0, CRC 15'h0000, delimiter 0 -> `crc_ok`=1, `form_err`=1. With the macro undefined -> `form_err`=0 and `done` arrives one strobe earlier.
- `frame_start` during RXCRC, then a fresh `crc_len`=1 frame with bit 1 / CRC 15'h4599 -> a single `done`, `crc_ok`=1, no stale `crc_rx` bits.
- `abort` in ACCUM -> IDLE, `busy`=0, no `done`. Async `reset` mid-frame -> all outputs return to their reset values immediately.
- `crc_len`=0 with `bit_valid` gaps of 3 cycles, CRC 15'h0000, delimiter 1 -> `crc_ok`=1, `done` the cycle after the delimiter strobe.
